// File: rtl/atm_code_sender.sv
// Drives a card-insert flag and a 3-digit access code onto cod, then waits for a cash or destroy reply and retries on timeout.
// Outputs decode the registered state with no input-to-output path, and the block accepts no backpressure.
module atm_code_sender #(
  parameter int HOLD_CYCLES = 2,
  parameter int RESP_WAIT   = 4,
  parameter int MAX_TRIES   = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] digit1,
  input  logic [2:0] digit2,
  input  logic [2:0] digit3,
  input  logic       dinheiro,
  input  logic       destroi,
  output logic       cartao,
  output logic [2:0] cod,
  output logic       busy,
  output logic       done_ok,
  output logic       done_fail,
  output logic       err,
  output logic [1:0] tries,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CARD      = 4'd1,
    SEND1     = 4'd2,
    SEND2     = 4'd3,
    SEND3     = 4'd4,
    WAIT_RESP = 4'd5,
    GAP       = 4'd6,
    DONE_OK   = 4'd7,
    DONE_FAIL = 4'd8
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RESP_LAST = 4'(RESP_WAIT - 1);
  localparam logic [1:0] MAX_T     = 2'(MAX_TRIES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] tries_q, tries_d;
  logic [2:0] d1_q, d1_d;
  logic [2:0] d2_q, d2_d;
  logic [2:0] d3_q, d3_d;
  logic       err_q, err_d;

  logic       code_ok;
  logic       hold_done;
  logic [1:0] tries_inc;

  // The receiver only advances on a change of symbol, so neighbouring digits must differ.
  assign code_ok   = (digit1 != 3'd0) && (digit2 != digit1) && (digit3 != digit2);
  assign hold_done = (cnt_q == HOLD_LAST);
  assign tries_inc = (tries_q >= MAX_T) ? tries_q : tries_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    tries_d = tries_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE, DONE_OK, DONE_FAIL: begin
        if (start) begin
          if (code_ok) begin
            d1_d    = digit1;
            d2_d    = digit2;
            d3_d    = digit3;
            tries_d = 2'd0;
            state_d = CARD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CARD:  if (hold_done) state_d = SEND1;
      SEND1: if (hold_done) state_d = SEND2;
      SEND2: if (hold_done) state_d = SEND3;
      SEND3: if (hold_done) state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (dinheiro) begin
          tries_d = tries_inc;
          state_d = DONE_OK;
        end else if (destroi) begin
          tries_d = tries_inc;
          state_d = DONE_FAIL;
        end else if (cnt_q == RESP_LAST) begin
          tries_d = tries_inc;
          state_d = (tries_inc < MAX_T) ? GAP : DONE_FAIL;
        end
      end
      GAP:   if (hold_done) state_d = SEND1;
      default: state_d = IDLE;
    endcase

    // Every state entry restarts the hold/response count from zero.
    if (state_d != state_q) cnt_d = 4'd0;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      tries_q <= 2'd0;
      d1_q    <= 3'd0;
      d2_q    <= 3'd0;
      d3_q    <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    cod  = 3'd0;
    case (state_q)
      CARD, WAIT_RESP, GAP: busy = 1'b1;
      SEND1: begin busy = 1'b1; cod = d1_q; end
      SEND2: begin busy = 1'b1; cod = d2_q; end
      SEND3: begin busy = 1'b1; cod = d3_q; end
      default: ;
    endcase
  end

  assign cartao    = busy;
  assign done_ok   = (state_q == DONE_OK);
  assign done_fail = (state_q == DONE_FAIL);
  assign err       = err_q;
  assign tries     = tries_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_atm_code_sender.sv
// Directed bench for atm_code_sender with default parameters (hold 2, response wait 4, 3 tries).
module tb_atm_code_sender;

  logic       clk_2 = 1'b0;
  logic       reset, start, dinheiro, destroi;
  logic [2:0] digit1, digit2, digit3;
  logic       cartao, busy, done_ok, done_fail, err;
  logic [2:0] cod;
  logic [1:0] tries;
  logic [3:0] state_dbg;

  int n_vec  = 0;
  int n_miss = 0;
  int q_cod[$];
  int q_st[$];
  int q_tr[$];

  atm_code_sender dut (
    .clk_2(clk_2), .reset(reset), .start(start),
    .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dinheiro(dinheiro), .destroi(destroi),
    .cartao(cartao), .cod(cod), .busy(busy),
    .done_ok(done_ok), .done_fail(done_fail), .err(err),
    .tries(tries), .state_dbg(state_dbg)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic go(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    digit1 = a; digit2 = b; digit3 = c;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic push(input int c, input int s, input int t, input int n);
    for (int k = 0; k < n; k++) begin
      q_cod.push_back(c); q_st.push_back(s); q_tr.push_back(t);
    end
  endtask

  function automatic logic [13:0] outs();
    return {cartao, cod, busy, done_ok, done_fail, err, tries, state_dbg};
  endfunction

  initial begin
    int exp_cod[8];
    exp_cod = '{0, 0, 1, 1, 3, 3, 7, 7};
    reset = 1'b1; start = 1'b0; dinheiro = 1'b0; destroi = 1'b0;
    digit1 = 3'd0; digit2 = 3'd0; digit3 = 3'd0;
    tick();
    reset = 1'b0;
    chk("reset_outs", 32'(outs()), 32'd0);

    // Code 1-3-7, cash on the third response cycle; a start mid-send must be ignored.
    go(3'd1, 3'd3, 3'd7);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s1_cod%0d", i), 32'(cod), 32'(exp_cod[i]));
      chk($sformatf("s1_cartao%0d", i), 32'(cartao), 32'd1);
      if (i == 3) begin
        digit1 = 3'd2; digit2 = 3'd4; digit3 = 3'd6; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("s1_wait_state", 32'(state_dbg), 32'd5);
    chk("s1_wait_cod", 32'(cod), 32'd0);
    chk("s1_busy_err", 32'({busy, err}), 32'b10);
    tick();
    tick();
    dinheiro = 1'b1;
    tick();
    dinheiro = 1'b0;
    chk("s1_done_state", 32'(state_dbg), 32'd7);
    chk("s1_done_ok", 32'(done_ok), 32'd1);
    chk("s1_tries", 32'(tries), 32'd1);
    chk("s1_cartao", 32'(cartao), 32'd0);

    // Restart from DONE_OK, then no reply for three attempts.
    go(3'd1, 3'd3, 3'd7);
    chk("s2_done_ok_clr", 32'(done_ok), 32'd0);
    chk("s2_tries_clr", 32'(tries), 32'd0);
    push(0, 1, 0, 2);
    for (int a = 0; a < 3; a++) begin
      push(1, 2, a, 2); push(3, 3, a, 2); push(7, 4, a, 2); push(0, 5, a, 4);
      if (a < 2) push(0, 6, a + 1, 2);
    end
    for (int i = 0; i < q_cod.size(); i++) begin
      chk($sformatf("s2_cod%0d", i), 32'(cod), 32'(q_cod[i]));
      chk($sformatf("s2_state%0d", i), 32'(state_dbg), 32'(q_st[i]));
      chk($sformatf("s2_tries%0d", i), 32'(tries), 32'(q_tr[i]));
      tick();
    end
    chk("s2_done_fail", 32'(done_fail), 32'd1);
    chk("s2_state", 32'(state_dbg), 32'd8);
    chk("s2_tries_end", 32'(tries), 32'd3);
    chk("s2_cartao", 32'(cartao), 32'd0);

    // Rejected codes: digit1 zero in DONE_FAIL, then 3-3 in IDLE.
    go(3'd0, 3'd2, 3'd4);
    chk("s3_err_a", 32'(err), 32'd1);
    chk("s3_hold_a", 32'({busy, done_fail, state_dbg}), 32'({1'b0, 1'b1, 4'd8}));
    tick();
    chk("s3_err_a_off", 32'(err), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    go(3'd3, 3'd3, 3'd5);
    chk("s3_err_b", 32'(err), 32'd1);
    chk("s3_hold_b", 32'({busy, state_dbg, tries}), 32'd0);
    tick();
    chk("s3_err_b_off", 32'(err), 32'd0);

    // Both responses together: cash wins.
    go(3'd2, 3'd5, 3'd1);
    repeat (8) tick();
    chk("s4_wait", 32'(state_dbg), 32'd5);
    dinheiro = 1'b1; destroi = 1'b1;
    tick();
    dinheiro = 1'b0; destroi = 1'b0;
    chk("s4_both", 32'({done_ok, done_fail, state_dbg}), 32'({1'b1, 1'b0, 4'd7}));
    chk("s4_both_tries", 32'(tries), 32'd1);

    // Destroy alone, with cash held high outside WAIT_RESP to show it is ignored there.
    go(3'd2, 3'd5, 3'd1);
    dinheiro = 1'b1;
    repeat (8) tick();
    dinheiro = 1'b0;
    chk("s4_ignore_cash", 32'(state_dbg), 32'd5);
    tick();
    destroi = 1'b1;
    tick();
    destroi = 1'b0;
    chk("s4_destroy", 32'({done_ok, done_fail, state_dbg}), 32'({1'b0, 1'b1, 4'd8}));
    chk("s4_destroy_tries", 32'(tries), 32'd1);

    // Reset during SEND2 overrides a simultaneous start.
    go(3'd1, 3'd3, 3'd7);
    repeat (4) tick();
    chk("s5_send2", 32'({state_dbg, cod}), 32'({4'd3, 3'd3}));
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("s5_reset_outs", 32'(outs()), 32'd0);
    tick();
    chk("s5_stay_idle", 32'(outs()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
